decode_stage: RTL and testbench
===============================

# decode_stage

Second stage of the five-stage RV32I pipeline. Consumes the instruction, PC and PC+4 latched by the fetch-to-decode register; decodes control, extends the immediate, reads the 32×32 register file, and latches everything into the decode-to-execute register. Also hosts the register file write port driven from writeback, with same-cycle write-to-read bypass.

## Interface
- `D_WIDTH`, default 32: datapath width.
- `REG_ADDR_W`, default 5: register index width.

Ports:
- `clk`  in  1  clock; every state element updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `FlushE`  in  1  loads a bubble into the decode-to-execute register.
- `InstrD`  in  32  instruction in decode.
- `PCD`  in  32  PC of `InstrD`.
- `PCPlus4D`  in  32  PC+4 of `InstrD`.
- `RegWriteW`  in  1  writeback enable.
- `RdW`  in  5  writeback destination.
- `ResultW`  in  32  writeback data.
- `Rs1D`, `Rs2D`  out  5 each  source indices, combinational, for the hazard unit.
- `RegWriteE`  out  1  registered control.
- `MemWriteE`  out  1  registered control.
- `JumpE`  out  1  registered control.
- `JalrE`  out  1  registered control.
- `BranchE`  out  1  registered control.
- `ALUSrcAE`  out  1  registered control; 1 selects PC.
- `ALUSrcBE`  out  1  registered control; 1 selects the immediate.
- `ResultSrcE`  out  2  registered: 00 ALU, 01 memory, 10 PC+4.
- `ALUControlE`  out  4  registered ALU operation.
- `Funct3E`  out  3  registered; branch type and load/store size.
- `RD1E`, `RD2E`, `ImmExtE`, `PCE`, `PCPlus4E`  out  32 each  registered data.
- `Rs1E`, `Rs2E`, `RdE`  out  5 each  registered indices.
- `a0`  out  32  live value of x10, for bench and display.

## Operation
- **Register file**
  - Write `ResultW` into `RdW` when `RegWriteW` is 1 and `RdW` is not 0.
  - x0 always reads 0.
  - Reads are combinational on `InstrD[19:15]` and `InstrD[24:20]`.
  - Bypass: if `RegWriteW` is 1, `RdW` equals the read index, and `RdW` is not 0, the read returns `ResultW`.
- **Immediate formats**
  - I: `{{20{i[31]}},i[31:20]}`.
  - S: `{{20{i[31]}},i[31:25],i[11:7]}`.
  - B: `{{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}`.
  - U: `{i[31:12],12'b0}`.
  - J: `{{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}`.
- **Opcode decode**
  - R (0110011): RegWrite; ALU op from funct3 and funct7[5].
  - I-ALU (0010011): RegWrite, ALUSrcB; funct7[5] is honoured only for SRAI.
  - Load (0000011): RegWrite, ALUSrcB, ResultSrc=01, ADD.
  - Store (0100011): MemWrite, ALUSrcB, S-immediate, ADD.
  - Branch (1100011): Branch, B-immediate, SUB.
  - JAL (1101111): Jump, RegWrite, ResultSrc=10, J-immediate.
  - JALR (1100111): Jump, Jalr, RegWrite, ALUSrcB, ResultSrc=10, ADD.
  - LUI (0110111): RegWrite, ALUSrcB, PASSB, U-immediate.
  - AUIPC (0010111): RegWrite, ALUSrcA, ALUSrcB, ADD, U-immediate.
  - Any other opcode: all control bits 0 (bubble); data fields still latch.
- **ALU encoding**
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100.
  - SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, PASSB 1010.
- `RdE` takes `InstrD[11:7]` and `Funct3E` takes `InstrD[14:12]`, whatever the opcode.

## Timing
- Decode-to-execute register latency is 1 cycle. Decode logic and register reads are combinational within the D cycle.
- `rst` at an edge:
  - Every E output goes to 0.
  - All 32 registers go to 0, so `a0` reads 0.
  - Overrides `FlushE` and any concurrent write, including a reset asserted mid-program.
- `FlushE` at an edge, without `rst`: every E output goes to 0, giving a NOP with all control deasserted. The register file still accepts the writeback in that cycle.
- There is no stall input. The stage's own input values are held by the upstream fetch-to-decode register.
- A write and a read of the same register in the same cycle return the new value via bypass. The array updates at the edge.
- A write to x0 is discarded, and a read of x0 returns 0 even if `RdW`=0 with `RegWriteW`=1.

## Structure
- Package `riscv_pkg`:
  - opcode localparams;
  - `alu_op_t` enum (4-bit, encodings above);
  - `imm_src_t` enum (I, S, B, U, J);
  - `result_src_t` (2-bit).
- Sub-module `reg_file`: 32×32 array, synchronous reset, write port, two bypassed read ports, `a0` tap.
- Control decode, immediate extension and the decode-to-execute register stay in `decode_stage`.

## Test plan
- **Bypass.** After reset, drive `addi x5,x0,-3` (0xFFD00293) with `RegWriteW`=1, `RdW`=5, `ResultW`=0x1234 in the same cycle. Next edge requires `RegWriteE`=1, `ALUSrcBE`=1, `ALUControlE`=0000, `ImmExtE`=0xFFFFFFFD, `RdE`=5, `RD1E`=0.
- **x0 write.** Write 0xDEADBEEF to x0, then decode `add x1,x0,x0`. Requires `RD1E`=`RD2E`=0.
- **Branch.** Decode `beq x1,x2,-8` (0xFE208CE3) with `PCD`=0x100. Requires `BranchE`=1, `ALUControlE`=0001, `ImmExtE`=0xFFFFFFF8, `PCE`=0x100, `RegWriteE`=0.
- **Flush.** Decode `jal x1,+16` (0x010000EF) and assert `FlushE` in the same cycle. All E outputs must be 0. Without the flush, `JumpE`=1, `ResultSrcE`=10, `ImmExtE`=0x10, `PCPlus4E`=`PCD`+4.
- **LUI and illegal opcode.** `lui x10,0x12345` then writeback of 0x12345000 to x10: requires `ALUControlE`=1010 and `a0`=0x12345000. Then decode an illegal opcode 0x0000007F: all E control bits must be 0.
- **Reset mid-program.** With non-zero E outputs and register contents, assert `rst` for one edge. All E outputs and `a0` must read 0 at that edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I decode types, opcodes and helper functions
// Purpose: opcode constants, ALU/immediate/result-select encodings, and the
//          immediate-extension and ALU-operation decode helpers used by decode_stage.
// Ports:   none (package).
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  // Only bits [31:7] carry immediate material; the opcode field never does.
  function automatic logic [31:0] imm_extend(input logic [31:7] i, input imm_src_t src);
    logic [31:0] imm;
    case (src)
      IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm = {i[31:12], 12'b0};
      IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = {{20{i[31]}}, i[31:20]};
    endcase
    return imm;
  endfunction

  // funct7[5] selects SUB only for register-register ops (ADDI has no SUBI);
  // for shifts it selects arithmetic right shift in both formats.
  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic f7b5,
                                         input logic is_r);
    alu_op_t op;
    case (f3)
      3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32-entry register file with write-to-read bypass
// Purpose: register array with synchronous reset, one write port and two
//          combinational read ports that forward same-cycle writeback data.
// Ports:   clk, rst (sync, active-high); we/wa/wd write port;
//          ra1/ra2 read indices -> rd1/rd2 read data; a0 live value of x10.
module reg_file #(
  parameter int D_WIDTH    = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [D_WIDTH-1:0]    wd,
  input  logic [REG_ADDR_W-1:0] ra1,
  input  logic [REG_ADDR_W-1:0] ra2,
  output logic [D_WIDTH-1:0]    rd1,
  output logic [D_WIDTH-1:0]    rd2,
  output logic [D_WIDTH-1:0]    a0
);

  localparam int NREG = 1 << REG_ADDR_W;

  logic [D_WIDTH-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // x0 check comes first so a writeback aimed at x0 is never forwarded.
  always_comb begin
    if (ra1 == '0)                rd1 = '0;
    else if (we && (wa == ra1))   rd1 = wd;
    else                          rd1 = regs[ra1];
  end

  always_comb begin
    if (ra2 == '0)                rd2 = '0;
    else if (we && (wa == ra2))   rd2 = wd;
    else                          rd2 = regs[ra2];
  end

  assign a0 = regs[10];

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with decode-to-execute register
// Purpose: decodes control and immediate from InstrD, reads the register file,
//          and latches everything into the decode-to-execute register.
// Ports:   clk, rst (sync, active-high), FlushE (bubble into E register);
//          InstrD/PCD/PCPlus4D from fetch; RegWriteW/RdW/ResultW writeback;
//          Rs1D/Rs2D combinational source indices; *E registered outputs; a0 tap.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int D_WIDTH    = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  FlushE,
  input  logic [31:0]           InstrD,
  input  logic [D_WIDTH-1:0]    PCD,
  input  logic [D_WIDTH-1:0]    PCPlus4D,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [D_WIDTH-1:0]    ResultW,
  output logic [REG_ADDR_W-1:0] Rs1D,
  output logic [REG_ADDR_W-1:0] Rs2D,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  JalrE,
  output logic                  BranchE,
  output logic                  ALUSrcAE,
  output logic                  ALUSrcBE,
  output logic [1:0]            ResultSrcE,
  output logic [3:0]            ALUControlE,
  output logic [2:0]            Funct3E,
  output logic [D_WIDTH-1:0]    RD1E,
  output logic [D_WIDTH-1:0]    RD2E,
  output logic [D_WIDTH-1:0]    ImmExtE,
  output logic [D_WIDTH-1:0]    PCE,
  output logic [D_WIDTH-1:0]    PCPlus4E,
  output logic [REG_ADDR_W-1:0] Rs1E,
  output logic [REG_ADDR_W-1:0] Rs2E,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic [D_WIDTH-1:0]    a0
);

  logic [6:0]   opcode;
  logic         reg_write, mem_write, jump, jalr, branch, src_a, src_b;
  result_src_t  result_src;
  alu_op_t      alu_ctl;
  imm_src_t     imm_src;
  logic [D_WIDTH-1:0] rd1, rd2, imm_ext;

  assign opcode = InstrD[6:0];
  assign Rs1D   = InstrD[15 +: REG_ADDR_W];
  assign Rs2D   = InstrD[20 +: REG_ADDR_W];

  reg_file #(.D_WIDTH(D_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_reg_file (
    .clk (clk),
    .rst (rst),
    .we  (RegWriteW),
    .wa  (RdW),
    .wd  (ResultW),
    .ra1 (Rs1D),
    .ra2 (Rs2D),
    .rd1 (rd1),
    .rd2 (rd2),
    .a0  (a0)
  );

  // Unknown opcodes fall through with every control bit low, i.e. a bubble.
  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    jump       = 1'b0;
    jalr       = 1'b0;
    branch     = 1'b0;
    src_a      = 1'b0;
    src_b      = 1'b0;
    result_src = RES_ALU;
    alu_ctl    = ALU_ADD;
    imm_src    = IMM_I;
    case (opcode)
      OP_R: begin
        reg_write = 1'b1;
        alu_ctl   = alu_decode(InstrD[14:12], InstrD[30], 1'b1);
      end
      OP_I: begin
        reg_write = 1'b1;
        src_b     = 1'b1;
        alu_ctl   = alu_decode(InstrD[14:12], InstrD[30], 1'b0);
      end
      OP_LOAD: begin
        reg_write  = 1'b1;
        src_b      = 1'b1;
        result_src = RES_MEM;
      end
      OP_STORE: begin
        mem_write = 1'b1;
        src_b     = 1'b1;
        imm_src   = IMM_S;
      end
      OP_BRANCH: begin
        branch  = 1'b1;
        alu_ctl = ALU_SUB;
        imm_src = IMM_B;
      end
      OP_JAL: begin
        jump       = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_PC4;
        imm_src    = IMM_J;
      end
      OP_JALR: begin
        jump       = 1'b1;
        jalr       = 1'b1;
        reg_write  = 1'b1;
        src_b      = 1'b1;
        result_src = RES_PC4;
      end
      OP_LUI: begin
        reg_write = 1'b1;
        src_b     = 1'b1;
        alu_ctl   = ALU_PASSB;
        imm_src   = IMM_U;
      end
      OP_AUIPC: begin
        reg_write = 1'b1;
        src_a     = 1'b1;
        src_b     = 1'b1;
        imm_src   = IMM_U;
      end
      default: ;
    endcase
  end

  assign imm_ext = D_WIDTH'(imm_extend(InstrD[31:7], imm_src));

  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      JalrE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcAE    <= 1'b0;
      ALUSrcBE    <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      Funct3E     <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
    end else begin
      RegWriteE   <= reg_write;
      MemWriteE   <= mem_write;
      JumpE       <= jump;
      JalrE       <= jalr;
      BranchE     <= branch;
      ALUSrcAE    <= src_a;
      ALUSrcBE    <= src_b;
      ResultSrcE  <= result_src;
      ALUControlE <= alu_ctl;
      Funct3E     <= InstrD[14:12];
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= imm_ext;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= InstrD[7 +: REG_ADDR_W];
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - table-driven self-checking bench for decode_stage
// Purpose: applies directed instruction/writeback vectors with hand-computed
//          expectations, then hand-written reset sequences.
// Ports:   none (top-level bench).
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, FlushE, RegWriteW;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcAE, ALUSrcBE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, a0;

  always #5 clk = ~clk;

  decode_stage #(.D_WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .FlushE(FlushE), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .JalrE(JalrE), .BranchE(BranchE), .ALUSrcAE(ALUSrcAE),
    .ALUSrcBE(ALUSrcBE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .a0(a0)
  );

  // ctrl = {RegWrite,MemWrite,Jump,Jalr,Branch,ALUSrcA,ALUSrcB,ResultSrc[1:0],ALUControl[3:0]}
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [12:0] ctrl;
    logic        chk_imm;
    logic [31:0] imm;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] a0;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic void add(input logic [31:0] instr, input logic [31:0] pc, input logic flush,
                              input logic wb_en, input logic [4:0] wb_rd, input logic [31:0] wb_data,
                              input logic [12:0] ctrl, input logic chk_imm, input logic [31:0] imm,
                              input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] a0v);
    vec_t v;
    v.instr = instr; v.pc = pc; v.flush = flush; v.wb_en = wb_en; v.wb_rd = wb_rd;
    v.wb_data = wb_data; v.ctrl = ctrl; v.chk_imm = chk_imm; v.imm = imm;
    v.rd1 = rd1; v.rd2 = rd2; v.a0 = a0v;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      n_miss++;
    end
  endtask

  function automatic logic [12:0] ctrl_now();
    return {RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcAE, ALUSrcBE,
            ResultSrcE, ALUControlE};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic flush,
                       input logic wb_en, input logic [4:0] wb_rd, input logic [31:0] wb_data);
    InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4; FlushE = flush;
    RegWriteW = wb_en; RdW = wb_rd; ResultW = wb_data;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ctrl"},   {19'd0, ctrl_now()}, 32'd0);
    chk({tag, " funct3"}, {29'd0, Funct3E}, 32'd0);
    chk({tag, " rd1"},    RD1E, 32'd0);
    chk({tag, " rd2"},    RD2E, 32'd0);
    chk({tag, " imm"},    ImmExtE, 32'd0);
    chk({tag, " pc"},     PCE, 32'd0);
    chk({tag, " pc4"},    PCPlus4E, 32'd0);
    chk({tag, " idx"},    {17'd0, Rs1E, Rs2E, RdE}, 32'd0);
    chk({tag, " a0"},     a0, 32'd0);
  endtask

  initial begin
    vec_t v;
    // addi x5,x0,-3 with writeback x5=0x1234 in the same cycle
    add(32'hFFD00293, 32'h000, 0, 1, 5'd5,  32'h1234,     13'b1_0_0_0_0_0_1_00_0000, 1, 32'hFFFFFFFD, 32'h0, 32'h0, 32'h0);
    // add x6,x5,x12 while x12<=0xABC is written: rs2 bypassed
    add(32'h00C28333, 32'h004, 0, 1, 5'd12, 32'h0ABC,     13'b1_0_0_0_0_0_0_00_0000, 0, 32'h0, 32'h1234, 32'h0ABC, 32'h0);
    // add x1,x0,x0 with writeback of 0xDEADBEEF to x0
    add(32'h000000B3, 32'h008, 0, 1, 5'd0,  32'hDEADBEEF, 13'b1_0_0_0_0_0_0_00_0000, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    // sub x2,x12,x0: x12 from the array, x0 still zero
    add(32'h40060133, 32'h00C, 0, 0, 5'd0,  32'h0,        13'b1_0_0_0_0_0_0_00_0001, 0, 32'h0, 32'h0ABC, 32'h0, 32'h0);
    // beq x1,x2,-8
    add(32'hFE208CE3, 32'h100, 0, 0, 5'd0,  32'h0,        13'b0_0_0_0_1_0_0_00_0001, 1, 32'hFFFFFFF8, 32'h0, 32'h0, 32'h0);
    // jal x1,+16
    add(32'h010000EF, 32'h200, 0, 0, 5'd0,  32'h0,        13'b1_0_1_0_0_0_0_10_0000, 1, 32'h10, 32'h0, 32'h0, 32'h0);
    // same jal flushed; writeback to x10 must still land
    add(32'h010000EF, 32'h200, 1, 1, 5'd10, 32'h777,      13'b0, 1, 32'h0, 32'h0, 32'h0, 32'h777);
    // lui x10,0x12345 with writeback 0x12345000 to x10
    add(32'h12345537, 32'h204, 0, 1, 5'd10, 32'h12345000, 13'b1_0_0_0_0_0_1_00_1010, 1, 32'h12345000, 32'h0, 32'h0, 32'h12345000);
    // illegal opcodes: bubble control, data still latched
    add(32'h0000007F, 32'h300, 0, 0, 5'd0,  32'h0,        13'b0, 0, 32'h0, 32'h0, 32'h0, 32'h12345000);
    add(32'h0005007F, 32'h304, 0, 0, 5'd0,  32'h0,        13'b0, 0, 32'h0, 32'h12345000, 32'h0, 32'h12345000);
    // sw x5,8(x10)
    add(32'h00552423, 32'h308, 0, 0, 5'd0,  32'h0,        13'b0_1_0_0_0_0_1_00_0000, 1, 32'h8, 32'h12345000, 32'h1234, 32'h12345000);
    // srai x11,x5,3
    add(32'h4032D593, 32'h30C, 0, 0, 5'd0,  32'h0,        13'b1_0_0_0_0_0_1_00_1001, 1, 32'h403, 32'h1234, 32'h0, 32'h12345000);
    // addi x1,x0,0x400: bit 30 set but must stay ADD
    add(32'h40000093, 32'h310, 0, 0, 5'd0,  32'h0,        13'b1_0_0_0_0_0_1_00_0000, 1, 32'h400, 32'h0, 32'h0, 32'h12345000);
    // jalr x1,4(x5)
    add(32'h004280E7, 32'h314, 0, 0, 5'd0,  32'h0,        13'b1_0_1_1_0_0_1_10_0000, 1, 32'h4, 32'h1234, 32'h0, 32'h12345000);
    // auipc x3,0x1
    add(32'h00001197, 32'h318, 0, 0, 5'd0,  32'h0,        13'b1_0_0_0_0_1_1_00_0000, 1, 32'h1000, 32'h0, 32'h0, 32'h12345000);
    // lw x4,0(x10)
    add(32'h00052203, 32'h31C, 0, 0, 5'd0,  32'h0,        13'b1_0_0_0_0_0_1_01_0000, 1, 32'h0, 32'h12345000, 32'h0, 32'h12345000);
    // or x8,x5,x10
    add(32'h00A2E433, 32'h320, 0, 0, 5'd0,  32'h0,        13'b1_0_0_0_0_0_0_00_0011, 0, 32'h0, 32'h1234, 32'h12345000, 32'h12345000);

    // reset state
    rst = 1'b1;
    drive(32'h0, 32'h0, 0, 0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    chk_all_zero("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v.instr, v.pc, v.flush, v.wb_en, v.wb_rd, v.wb_data);
      #1;
      chk($sformatf("v%0d Rs1D", i), {27'd0, Rs1D}, {27'd0, v.instr[19:15]});
      chk($sformatf("v%0d Rs2D", i), {27'd0, Rs2D}, {27'd0, v.instr[24:20]});
      @(posedge clk);
      #1;
      n_vec++;
      chk($sformatf("v%0d ctrl", i), {19'd0, ctrl_now()}, {19'd0, v.ctrl});
      if (v.chk_imm) chk($sformatf("v%0d imm", i), ImmExtE, v.imm);
      chk($sformatf("v%0d rd1", i), RD1E, v.rd1);
      chk($sformatf("v%0d rd2", i), RD2E, v.rd2);
      chk($sformatf("v%0d pc", i), PCE, v.flush ? 32'h0 : v.pc);
      chk($sformatf("v%0d pc4", i), PCPlus4E, v.flush ? 32'h0 : v.pc + 32'd4);
      chk($sformatf("v%0d funct3", i), {29'd0, Funct3E}, v.flush ? 32'h0 : {29'd0, v.instr[14:12]});
      chk($sformatf("v%0d rd", i), {27'd0, RdE}, v.flush ? 32'h0 : {27'd0, v.instr[11:7]});
      chk($sformatf("v%0d rs1e", i), {27'd0, Rs1E}, v.flush ? 32'h0 : {27'd0, v.instr[19:15]});
      chk($sformatf("v%0d rs2e", i), {27'd0, Rs2E}, v.flush ? 32'h0 : {27'd0, v.instr[24:20]});
      chk($sformatf("v%0d a0", i), a0, v.a0);
    end

    // mid-program reset: lui decoded and a write to x10 in flight, rst wins
    drive(32'h12345537, 32'h400, 0, 1, 5'd10, 32'h999);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    chk_all_zero("midrst");
    rst = 1'b0;

    // reset plus flush together still yields zeros
    drive(32'h00A2E433, 32'h404, 1, 0, 5'd0, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    chk_all_zero("rstflush");
    rst = 1'b0;

    // add x1,x10,x0 after reset: x10 must have been cleared
    drive(32'h000500B3, 32'h408, 0, 0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    n_vec++;
    chk("postrst ctrl", {19'd0, ctrl_now()}, {19'd0, 13'b1_0_0_0_0_0_0_00_0000});
    chk("postrst rd1", RD1E, 32'h0);
    chk("postrst pc",  PCE, 32'h408);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
